// File: rtl/scalar_accel_arbiter_pkg.sv
// Shared definitions for the Scalar accelerator arbiter: FSM state encoding and a
// width helper for deriving address/counter widths from count parameters.
package scalar_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Minimum width to address 'value' distinct items; never returns less than 1.
  function automatic int clog2_f(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/scalar_accel_arbiter_if.sv
// Accelerator-side bus of the arbiter. The i_/o_ prefixes are from the arbiter's
// point of view: accelerators (master) drive i_*, the arbiter (slave) drives o_*.
interface scalar_accel_arbiter_if #(
  parameter int REQ_COUNT         = 4,
  parameter int THREAD_ADDR_WIDTH = 3
);

  logic [REQ_COUNT-1:0]         i_req;
  logic [REQ_COUNT-1:0]         i_release;
  logic [REQ_COUNT-1:0]         i_req_i_wren;
  logic [REQ_COUNT-1:0]         i_req_a_wren;
  logic [REQ_COUNT-1:0]         i_req_b_wren;
  logic [REQ_COUNT-1:0]         i_req_c_in;

  logic [REQ_COUNT-1:0]         o_grant;
  logic                         o_i_wren_other;
  logic                         o_a_wren_other;
  logic                         o_b_wren_other;
  logic                         o_alu_c_in;
  logic                         o_busy;
  logic [THREAD_ADDR_WIDTH-1:0] o_thread_slot;

  modport master (
    output i_req, i_release, i_req_i_wren, i_req_a_wren, i_req_b_wren, i_req_c_in,
    input  o_grant, o_i_wren_other, o_a_wren_other, o_b_wren_other, o_alu_c_in,
           o_busy, o_thread_slot
  );

  modport slave (
    input  i_req, i_release, i_req_i_wren, i_req_a_wren, i_req_b_wren, i_req_c_in,
    output o_grant, o_i_wren_other, o_a_wren_other, o_b_wren_other, o_alu_c_in,
           o_busy, o_thread_slot
  );

endinterface

// File: rtl/scalar_accel_arbiter_rr_priority_pick.sv
// Round-robin picker: first requesting index strictly after i_rr_ptr, wrapping
// around, so the previous winner has the lowest priority. Purely combinational.
module rr_priority_pick
  import scalar_accel_pkg::*;
#(
  parameter int REQ_COUNT      = 4,
  parameter int REQ_ADDR_WIDTH = clog2_f(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0]      i_req,
  input  logic [REQ_ADDR_WIDTH-1:0] i_rr_ptr,
  output logic [REQ_COUNT-1:0]      o_pick,
  output logic [REQ_ADDR_WIDTH-1:0] o_pick_idx,
  output logic                      o_valid
);

  logic [REQ_ADDR_WIDTH-1:0] w_cand;

  always_comb begin
    o_pick     = '0;
    o_pick_idx = '0;
    o_valid    = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      w_cand = REQ_ADDR_WIDTH'((int'(i_rr_ptr) + k) % REQ_COUNT);
      if (!o_valid && i_req[w_cand]) begin
        o_valid        = 1'b1;
        o_pick_idx     = w_cand;
        o_pick[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scalar_accel_arbiter.sv
// Shares one Scalar core's memory-write enables and ALU carry-in among several
// accelerators; ownership moves only at barrel-round boundaries.
//
// state | meaning
// IDLE  | no owner, nobody was requesting at the last boundary
// GRANT | one accelerator owns the Scalar control inputs for whole rounds
// DRAIN | one quiet round after ownership ends so in-flight writes retire
module scalar_accel_arbiter
  import scalar_accel_pkg::*;
#(
  parameter int REQ_COUNT         = 4,
  parameter int REQ_ADDR_WIDTH    = clog2_f(REQ_COUNT),
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = clog2_f(THREAD_COUNT),
  parameter int MAX_HOLD_ROUNDS   = 4,
  parameter int HOLD_WIDTH        = clog2_f(MAX_HOLD_ROUNDS + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  scalar_accel_arbiter_if.slave bus
);

  arb_state_t                   r_state;
  arb_state_t                   w_state_nxt;
  logic [THREAD_ADDR_WIDTH-1:0] r_thread_slot;
  logic [HOLD_WIDTH-1:0]        r_hold;
  logic [HOLD_WIDTH-1:0]        w_hold_nxt;
  logic [REQ_ADDR_WIDTH-1:0]    r_rr_ptr;
  logic [REQ_ADDR_WIDTH-1:0]    w_rr_ptr_nxt;
  logic [REQ_COUNT-1:0]         r_grant;
  logic [REQ_COUNT-1:0]         w_grant_nxt;

  logic                         w_boundary;
  logic                         w_owner_req;
  logic                         w_owner_rel;
  logic                         w_others_pending;
  logic                         w_hold_expired;
  logic                         w_active;
  logic [REQ_COUNT-1:0]         w_pick;
  logic [REQ_ADDR_WIDTH-1:0]    w_pick_idx;
  logic                         w_pick_valid;

  rr_priority_pick #(
    .REQ_COUNT      (REQ_COUNT),
    .REQ_ADDR_WIDTH (REQ_ADDR_WIDTH)
  ) u_pick (
    .i_req      (bus.i_req),
    .i_rr_ptr   (r_rr_ptr),
    .o_pick     (w_pick),
    .o_pick_idx (w_pick_idx),
    .o_valid    (w_pick_valid)
  );

  assign w_boundary       = (r_thread_slot == THREAD_ADDR_WIDTH'(THREAD_COUNT - 1));
  assign w_owner_req      = |(r_grant & bus.i_req);
  assign w_owner_rel      = |(r_grant & bus.i_release);
  assign w_others_pending = |(bus.i_req & ~r_grant);
  // >= rather than == so a saturated hold (long uncontested ownership) still yields.
  assign w_hold_expired   = (r_hold >= HOLD_WIDTH'(MAX_HOLD_ROUNDS - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_thread_slot <= '0;
      r_hold        <= '0;
      r_rr_ptr      <= REQ_ADDR_WIDTH'(REQ_COUNT - 1);
      r_grant       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_thread_slot <= w_boundary ? '0 : r_thread_slot + 1'b1;
      r_hold        <= w_hold_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant       <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant;
    unique case (r_state)
      ST_IDLE, ST_DRAIN: begin
        w_grant_nxt = '0;
        if (w_boundary) begin
          if (w_pick_valid) begin
            w_state_nxt  = ST_GRANT;
            w_grant_nxt  = w_pick;
            w_rr_ptr_nxt = w_pick_idx;
            w_hold_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GRANT: begin
        // Release beats every boundary decision, and never hands off directly.
        if (w_owner_rel) begin
          w_state_nxt = ST_DRAIN;
          w_grant_nxt = '0;
        end else if (w_boundary) begin
          if (!w_owner_req || (w_others_pending && w_hold_expired)) begin
            w_state_nxt = ST_DRAIN;
            w_grant_nxt = '0;
          end else if (r_hold != HOLD_WIDTH'(MAX_HOLD_ROUNDS)) begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign w_active = (r_state == ST_GRANT);

  assign bus.o_grant        = r_grant;
  assign bus.o_i_wren_other = w_active & |(r_grant & bus.i_req_i_wren);
  assign bus.o_a_wren_other = w_active & |(r_grant & bus.i_req_a_wren);
  assign bus.o_b_wren_other = w_active & |(r_grant & bus.i_req_b_wren);
  assign bus.o_alu_c_in     = w_active & |(r_grant & bus.i_req_c_in);
  assign bus.o_busy         = (r_state != ST_IDLE);
  assign bus.o_thread_slot  = r_thread_slot;

endmodule

// File: tb/tb_scalar_accel_arbiter.sv
// Self-checking bench for scalar_accel_arbiter: directed scenarios plus random
// traffic, compared every cycle against an ownership-level reference model.
module tb_scalar_accel_arbiter;

  localparam int REQ_COUNT    = 4;
  localparam int THREAD_COUNT = 8;
  localparam int MAX_HOLD     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scalar_accel_arbiter_if #(.REQ_COUNT(REQ_COUNT), .THREAD_ADDR_WIDTH(3)) bus ();

  scalar_accel_arbiter #(
    .REQ_COUNT       (REQ_COUNT),
    .THREAD_COUNT    (THREAD_COUNT),
    .MAX_HOLD_ROUNDS (MAX_HOLD)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: which accelerator owns the Scalar, how many full rounds it
  // has held, whether a quiet round is in progress, and who won last.
  int m_slot   = 0;
  int m_owner  = -1;
  int m_rounds = 0;
  int m_last   = REQ_COUNT - 1;
  bit m_quiet  = 1'b0;
  bit m_valid  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit owner_bit(input logic [3:0] v);
    int o;
    o = m_owner;
    if (o < 0) return 1'b0;
    return v[o[1:0]];
  endfunction

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check_eq("grant",     32'(bus.o_grant),        32'(eg));
    check_eq("slot",      32'(bus.o_thread_slot),  32'(m_slot));
    check_eq("busy",      32'(bus.o_busy),         32'(m_owner >= 0 || m_quiet));
    check_eq("i_wren",    32'(bus.o_i_wren_other), 32'(owner_bit(bus.i_req_i_wren)));
    check_eq("a_wren",    32'(bus.o_a_wren_other), 32'(owner_bit(bus.i_req_a_wren)));
    check_eq("b_wren",    32'(bus.o_b_wren_other), 32'(owner_bit(bus.i_req_b_wren)));
    check_eq("alu_c_in",  32'(bus.o_alu_c_in),     32'(owner_bit(bus.i_req_c_in)));
  endtask

  task automatic model_step();
    logic [3:0] rq;
    bit end_of_round;
    int cand;
    rq = bus.i_req;
    if (rst) begin
      m_slot = 0; m_owner = -1; m_rounds = 0; m_last = REQ_COUNT - 1; m_quiet = 1'b0;
      return;
    end
    end_of_round = (m_slot == THREAD_COUNT - 1);
    if (m_owner >= 0 && owner_bit(bus.i_release)) begin
      m_owner = -1;
      m_quiet = 1'b1;
    end else if (end_of_round) begin
      if (m_owner >= 0) begin
        m_rounds++;
        if (!owner_bit(rq) || (((rq & ~4'(1 << m_owner)) != 0) && m_rounds >= MAX_HOLD)) begin
          m_owner = -1;
          m_quiet = 1'b1;
        end
      end else begin
        m_quiet = 1'b0;
        for (int k = 1; k <= REQ_COUNT; k++) begin
          cand = (m_last + k) % REQ_COUNT;
          if (m_owner < 0 && rq[cand[1:0]]) m_owner = cand;
        end
        if (m_owner >= 0) begin
          m_last   = m_owner;
          m_rounds = 0;
        end
      end
    end
    m_slot = (m_slot + 1) % THREAD_COUNT;
  endtask

  // One clock: drive at the falling edge, check combinational outputs 1 ns later,
  // let the rising edge consume the inputs, then advance the model.
  task automatic step(input logic [3:0] rq, input logic [3:0] rl, input logic [3:0] iw,
                      input logic [3:0] aw, input logic [3:0] bw, input logic [3:0] ci,
                      input logic r);
    bus.i_req = rq; bus.i_release = rl; bus.i_req_i_wren = iw;
    bus.i_req_a_wren = aw; bus.i_req_b_wren = bw; bus.i_req_c_in = ci;
    rst = r;
    #1;
    if (m_valid) check_outputs();
    @(posedge clk);
    model_step();
    m_valid = 1'b1;
    @(negedge clk);
  endtask

  logic [3:0] r_req_rand;
  logic [3:0] r_rel_rand;

  initial begin
    @(negedge clk);

    // Reset with everyone requesting; requester 0 wins at the first slot 0.
    repeat (3) step(4'b1111, 4'b0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1);
    repeat (8) step(4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    #1;
    check_eq("t1_grant", 32'(bus.o_grant), 32'h1);
    check_eq("t1_slot",  32'(bus.o_thread_slot), 32'h0);

    // Reset in the middle of an ownership drops it at once.
    repeat (3) step(4'b1111, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b1111, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 1'b1);
    #1;
    check_eq("t6_grant", 32'(bus.o_grant), 32'h0);
    check_eq("t6_slot",  32'(bus.o_thread_slot), 32'h0);
    check_eq("t6_wren",  32'(bus.o_i_wren_other), 32'h0);

    // Single requester 2 arriving at slot 3.
    repeat (3) step(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    repeat (5) step(4'b0100, 4'b0, 4'b0, 4'b0100, 4'b0, 4'b0, 1'b0);
    bus.i_req_a_wren = 4'b0100;
    #1;
    check_eq("t2_grant", 32'(bus.o_grant), 32'h4);
    check_eq("t2_awren", 32'(bus.o_a_wren_other), 32'h1);

    // Owner releases at slot 5; outputs go quiet from slot 6, idle after the round.
    repeat (5) step(4'b0100, 4'b0, 4'b0, 4'b0100, 4'b0, 4'b0, 1'b0);
    step(4'b0100, 4'b0100, 4'b0, 4'b0100, 4'b0, 4'b0, 1'b0);
    bus.i_req_a_wren = 4'b0100;
    #1;
    check_eq("t4_grant", 32'(bus.o_grant), 32'h0);
    check_eq("t4_awren", 32'(bus.o_a_wren_other), 32'h0);
    repeat (2) step(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    #1;
    check_eq("t4_busy", 32'(bus.o_busy), 32'h0);

    // Requester 0 owns; requester 3's writes and release pulses must not matter.
    repeat (8) step(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    repeat (4) step(4'b0001, 4'b1000, 4'b0, 4'b0, 4'b1000, 4'b0, 1'b0);
    bus.i_req_b_wren = 4'b1000;
    #1;
    check_eq("t5_grant", 32'(bus.o_grant), 32'h1);
    check_eq("t5_bwren", 32'(bus.o_b_wren_other), 32'h0);

    // Two continuous requesters alternate under the hold limit.
    repeat (THREAD_COUNT * 16)
      step(4'b0011, 4'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);

    // Random traffic with slowly changing requests, rare releases and resets.
    r_req_rand = 4'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < REQ_COUNT; b++)
        if ($urandom_range(0, 15) == 0) r_req_rand[b] = ~r_req_rand[b];
      r_rel_rand = ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      step(r_req_rand, r_rel_rand, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           logic'($urandom_range(0, 499) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
